axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
AXI-lite responder (slave end) backed by an internal word-addressed memory array; serves the shared bus driven by the IFU/LSU arbitration mux.
Independent read and write channel state machines with configurable fixed latency. Full wstrb byte-lane support and address-range decoding with error responses.
Used as the simulation/SoC memory target and as the verification responder for the master side.

Parameters:
BASE, 32'h8000_0000, byte address of word 0
DEPTH, 256, number of 64-bit words (power of 2)
RD_LAT, 1, cycles from AR handshake to rvalid (>=1)
WR_LAT, 1, cycles from last of AW/W handshake to bvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  64  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  64  write data
wstrb  in  8  byte strobes, bit i enables wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset: while rst=1, arready/awready/wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; both FSMs -> IDLE; in-flight transactions are dropped. Memory contents are not reset.
- Decode: hit iff BASE <= addr < BASE+DEPTH*8; index = (addr-BASE)>>3; addr[2:0] ignored. Hit -> resp 2'b00 OKAY; miss -> 2'b11 DECERR, rdata=0, write discarded.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid, latch araddr -> R_WAIT with counter=RD_LAT-1.
  - R_WAIT: arready=0; count down. At 0, sample mem and load rdata/rresp -> R_RESP, rvalid=1. Net: AR handshake at edge T gives rvalid high at T+RD_LAT.
  - R_RESP: rdata/rresp/rvalid held stable until rready; on rvalid&rready -> R_IDLE (rvalid=0 next cycle). New AR accepted no earlier than the cycle after the R handshake.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until AW captured, wready=1 until W captured. AW and W may arrive in either order or in the same cycle; each is latched independently.
  - When both are held -> W_WAIT with counter=WR_LAT-1.
  - At 0, commit: bytes with wstrb=1 are written; wstrb=0 bytes are unchanged. Then -> W_RESP with bvalid=1, bresp per decode.
  - W_RESP: hold until bready; -> W_IDLE.
- Read and write channels are fully concurrent. If a write commit and a read sample hit the same word on the same edge, the read returns old data.
- wstrb=8'h00 on a hit: OKAY response, memory unchanged.

Optional Feature:
AXI_SRAM_RAND_LAT_EN:
- Defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1, advances every cycle). Each read/write wait count is loaded with base latency-1 plus lfsr[1:0] (0-3 extra cycles), to stress master handshakes.
- Undefined: latency is exactly RD_LAT/WR_LAT; no LFSR logic.

Test Plan:
- Write 0x8000_0010 wdata=64'h1122334455667788 wstrb=8'hFF, then read the same address (RD_LAT=1) -> bresp=00; rvalid exactly 1 cycle after AR handshake; rdata=64'h1122334455667788, rresp=00.
- Partial write wstrb=8'h0F wdata=64'hAAAAAAAA_BBBBBBBB onto the previous word -> readback 64'h11223344_BBBBBBBB.
- W presented 3 cycles before AW -> wready drops after W handshake; bvalid rises WR_LAT cycles after the AW handshake; single write committed.
- Read 0x7FFF_FFF8 and write 0x8000_0800 (DEPTH=256) -> rresp=11, rdata=0; bresp=11; memory unchanged.
- Hold rready=0 for 5 cycles with rvalid=1 -> rdata/rresp stable, arready=0 throughout; a second arvalid is not accepted until the cycle after rready=1.
- Assert rst during R_WAIT and W_WAIT -> next cycle rvalid=bvalid=0, FSMs idle; after release, a fresh read of 0x8000_0010 returns the pre-reset contents.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite SRAM responder: word-addressed 64-bit memory, DECERR outside [BASE, BASE+DEPTH*8); optional AXI_SRAM_RAND_LAT_EN adds 0-3 LFSR cycles.
// Latency AR->rvalid RD_LAT, last AW/W->bvalid WR_LAT; R/B responses held until rready/bready, no new request meanwhile.
module axi_lite_sram_slave #(
   parameter logic [31:0] BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned WR_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] SPAN        = 33'(DEPTH) << 3;
   localparam logic [15:0] RD_BASE_CNT = 16'(RD_LAT - 1);
   localparam logic [15:0] WR_BASE_CNT = 16'(WR_LAT - 1);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

   function automatic logic dec_hit(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && ({1'b0, off} < SPAN);
   endfunction

   function automatic logic [IW-1:0] dec_idx(input logic [31:0] a);
      return IW'((a - BASE) >> 3);
   endfunction

   logic [63:0] mem [DEPTH];

   logic [15:0] rd_load;
   logic [15:0] wr_load;

`ifdef AXI_SRAM_RAND_LAT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= 16'hACE1;
      else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign rd_load = RD_BASE_CNT + {14'd0, lfsr[1:0]};
   assign wr_load = WR_BASE_CNT + {14'd0, lfsr[1:0]};
`else
   assign rd_load = RD_BASE_CNT;
   assign wr_load = WR_BASE_CNT;
`endif

   // ---------------- read channel ----------------
   rd_state_t   r_state, r_state_nx;
   logic [15:0] r_cnt, r_cnt_nx;
   logic [31:0] r_addr;
   logic        ar_take, r_load;
   logic        rd_hit;
   logic [IW-1:0] r_idx;

   assign rd_hit  = dec_hit(r_addr);
   assign r_idx   = dec_idx(r_addr);
   assign arready = ~rst & (r_state == R_IDLE);
   assign rvalid  = ~rst & (r_state == R_RESP);

   always_comb begin
      r_state_nx = r_state;
      r_cnt_nx   = r_cnt;
      ar_take    = 1'b0;
      r_load     = 1'b0;
      case (r_state)
         R_IDLE: if (arvalid) begin
            ar_take    = 1'b1;
            r_cnt_nx   = rd_load;
            r_state_nx = R_WAIT;
         end
         R_WAIT: if (r_cnt == 16'd0) begin
            r_load     = 1'b1;
            r_state_nx = R_RESP;
         end else begin
            r_cnt_nx = r_cnt - 16'd1;
         end
         R_RESP: if (rready) r_state_nx = R_IDLE;
         default: r_state_nx = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_cnt   <= 16'd0;
         r_addr  <= 32'd0;
         rdata   <= 64'd0;
         rresp   <= 2'b00;
      end else begin
         r_state <= r_state_nx;
         r_cnt   <= r_cnt_nx;
         if (ar_take) r_addr <= araddr;
         // Sampled with the pre-edge memory value, so a same-edge write is not seen.
         if (r_load) begin
            rdata <= rd_hit ? mem[r_idx] : 64'd0;
            rresp <= rd_hit ? 2'b00 : 2'b11;
         end
      end
   end

   // ---------------- write channel ----------------
   wr_state_t   w_state, w_state_nx;
   logic [15:0] w_cnt, w_cnt_nx;
   logic [31:0] aw_addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wstrb_q;
   logic        aw_held, w_held;
   logic        aw_take, w_take, commit;
   logic        wr_hit;
   logic [IW-1:0] w_idx;

   assign wr_hit  = dec_hit(aw_addr_q);
   assign w_idx   = dec_idx(aw_addr_q);
   assign awready = ~rst & (w_state == W_IDLE) & ~aw_held;
   assign wready  = ~rst & (w_state == W_IDLE) & ~w_held;
   assign bvalid  = ~rst & (w_state == W_RESP);

   always_comb begin
      w_state_nx = w_state;
      w_cnt_nx   = w_cnt;
      aw_take    = 1'b0;
      w_take     = 1'b0;
      commit     = 1'b0;
      case (w_state)
         W_IDLE: begin
            aw_take = awvalid & ~aw_held;
            w_take  = wvalid & ~w_held;
            if ((aw_held | aw_take) & (w_held | w_take)) begin
               w_cnt_nx   = wr_load;
               w_state_nx = W_WAIT;
            end
         end
         W_WAIT: if (w_cnt == 16'd0) begin
            commit     = ~rst;
            w_state_nx = W_RESP;
         end else begin
            w_cnt_nx = w_cnt - 16'd1;
         end
         W_RESP: if (bready) w_state_nx = W_IDLE;
         default: w_state_nx = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         w_cnt     <= 16'd0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= 32'd0;
         wdata_q   <= 64'd0;
         wstrb_q   <= 8'd0;
         bresp     <= 2'b00;
      end else begin
         w_state <= w_state_nx;
         w_cnt   <= w_cnt_nx;
         if (aw_take) begin
            aw_addr_q <= awaddr;
            aw_held   <= 1'b1;
         end
         if (w_take) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_held  <= 1'b1;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bresp   <= wr_hit ? 2'b00 : 2'b11;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit && wr_hit) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb_q[i]) mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: directed scenarios plus randomized traffic against an array memory model.
module tb_axi_lite_sram_slave;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          DEPTH  = 256;
   localparam int          RD_LAT = 1;
   localparam int          WR_LAT = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] ref_mem [DEPTH];

   axi_lite_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit m_hit(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la >= 64'h8000_0000) && (la < 64'h8000_0000 + DEPTH * 8);
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return int'((la - 64'h8000_0000) / 8);
   endfunction

   function automatic void m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] mask;
      mask = 64'd0;
      for (int i = 0; i < 8; i++)
         if (s[i]) mask = mask | (64'hFF << (8 * i));
      if (m_hit(a)) ref_mem[m_idx(a)] = (ref_mem[m_idx(a)] & ~mask) | (d & mask);
   endfunction

   function automatic logic [63:0] m_rdata(input logic [31:0] a);
      return m_hit(a) ? ref_mem[m_idx(a)] : 64'd0;
   endfunction

   function automatic logic [1:0] m_resp(input logic [31:0] a);
      return m_hit(a) ? 2'b00 : 2'b11;
   endfunction

   // ---------------- transaction drivers (no checking) ----------------
   task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int lat, output bit to);
      bit aw_done, w_done, aw_hs, w_hs;
      int c;
      aw_done = 0; w_done = 0; c = 0; to = 0; lat = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && c < 60) begin
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk); #1;
         c++;
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done  = 1;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) to = 1;
      while (!bvalid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bvalid) to = 1;
      resp = bresp;
      repeat (b_dly) begin @(posedge clk); #1; end
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic do_read(input logic [31:0] a, input int r_dly,
                          output logic [63:0] d, output logic [1:0] resp, output int lat, output bit to);
      bit hs;
      int c;
      hs = 0; c = 0; to = 0; lat = 0;
      araddr = a; arvalid = 1;
      while (!hs && c < 60) begin
         hs = arready;
         @(posedge clk); #1;
         c++;
      end
      arvalid = 0;
      if (!hs) to = 1;
      while (!rvalid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!rvalid) to = 1;
      d = rdata; resp = rresp;
      repeat (r_dly) begin @(posedge clk); #1; end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst = 1;
      arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
      araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: ar/aw/w/rv/bv=%b expected 00000", {arready, awready, wready, rvalid, bvalid});
      end
      vectors++;
      if ({rdata, rresp, bresp} !== 68'd0) begin
         miscompares++;
         $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b expected zeros", rdata, rresp, bresp);
      end
      rst = 0;
      @(posedge clk); #1;
      vectors++;
      if ({arready, awready, wready} !== 3'b111) begin
         miscompares++;
         $display("FAIL reset_idle_ready: ar/aw/w=%b expected 111", {arready, awready, wready});
      end
   endtask

   task automatic test_basic_write_read;
      logic [1:0] resp; logic [63:0] d; int lat; bit to;
      do_write(BASE + 32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0, resp, lat, to);
      m_write(BASE + 32'h10, 64'h1122334455667788, 8'hFF);
      vectors++;
      if (to || resp !== 2'b00 || lat !== WR_LAT) begin
         miscompares++;
         $display("FAIL basic_write: to=%0d bresp=%b lat=%0d expected 0/00/%0d", to, resp, lat, WR_LAT);
      end
      do_read(BASE + 32'h10, 0, d, resp, lat, to);
      vectors++;
      if (to || lat !== RD_LAT) begin
         miscompares++;
         $display("FAIL basic_read_lat: to=%0d lat=%0d expected 0/%0d", to, lat, RD_LAT);
      end
      vectors++;
      if (d !== 64'h1122334455667788 || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL basic_read_data: rdata=%h rresp=%b expected 1122334455667788/00", d, resp);
      end
   endtask

   task automatic test_partial_write;
      logic [1:0] resp; logic [63:0] d; int lat; bit to;
      do_write(BASE + 32'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0, 0, 0, resp, lat, to);
      m_write(BASE + 32'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
      do_read(BASE + 32'h10, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== 64'h11223344_BBBBBBBB || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL partial_write: rdata=%h rresp=%b expected 11223344bbbbbbbb/00", d, resp);
      end
      do_write(BASE + 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 0, resp, lat, to);
      do_read(BASE + 32'h10, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== 64'h11223344_BBBBBBBB) begin
         miscompares++;
         $display("FAIL zero_strobe: rdata=%h expected 11223344bbbbbbbb", d);
      end
   endtask

   task automatic test_w_before_aw;
      logic [1:0] resp; logic [63:0] d; int lat; bit to;
      wdata = 64'h0102_0304_0506_0708; wstrb = 8'hFF; wvalid = 1;
      vectors++;
      if (wready !== 1'b1) begin
         miscompares++;
         $display("FAIL wfirst_wready: wready=%b expected 1", wready);
      end
      @(posedge clk); #1;
      wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wfirst_hold[%0d]: wready=%b awready=%b bvalid=%b expected 0/1/0", i, wready, awready, bvalid);
         end
         @(posedge clk); #1;
      end
      awaddr = BASE + 32'h18; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0;
      lat = 0;
      while (!bvalid && lat < 60) begin @(posedge clk); #1; lat++; end
      vectors++;
      if (lat !== WR_LAT || bresp !== 2'b00) begin
         miscompares++;
         $display("FAIL wfirst_bvalid: lat=%0d bresp=%b expected %0d/00", lat, bresp, WR_LAT);
      end
      bready = 1; @(posedge clk); #1; bready = 0;
      m_write(BASE + 32'h18, 64'h0102_0304_0506_0708, 8'hFF);
      do_read(BASE + 32'h18, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== m_rdata(BASE + 32'h18)) begin
         miscompares++;
         $display("FAIL wfirst_readback: rdata=%h expected %h", d, m_rdata(BASE + 32'h18));
      end
   endtask

   task automatic test_decode_errors;
      logic [1:0] resp; logic [63:0] d; int lat; bit to;
      do_write(BASE, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 0, resp, lat, to);
      m_write(BASE, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      do_write(BASE + 32'h7F8, 64'h5555_6666_7777_8888, 8'hFF, 0, 0, 0, resp, lat, to);
      m_write(BASE + 32'h7F8, 64'h5555_6666_7777_8888, 8'hFF);
      vectors++;
      if (to || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL last_word_write: bresp=%b expected 00", resp);
      end
      do_write(32'h8000_0800, 64'hFFFF_0000_FFFF_0000, 8'hFF, 0, 0, 0, resp, lat, to);
      vectors++;
      if (to || resp !== 2'b11) begin
         miscompares++;
         $display("FAIL decerr_write: bresp=%b expected 11", resp);
      end
      do_read(32'h7FFF_FFF8, 0, d, resp, lat, to);
      vectors++;
      if (to || resp !== 2'b11 || d !== 64'd0) begin
         miscompares++;
         $display("FAIL decerr_read_low: rdata=%h rresp=%b expected 0/11", d, resp);
      end
      do_read(32'h8000_0800, 0, d, resp, lat, to);
      vectors++;
      if (to || resp !== 2'b11 || d !== 64'd0) begin
         miscompares++;
         $display("FAIL decerr_read_high: rdata=%h rresp=%b expected 0/11", d, resp);
      end
      do_read(BASE, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== 64'hDEAD_BEEF_0123_4567 || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL decerr_no_alias: rdata=%h expected deadbeef01234567", d);
      end
      do_read(BASE + 32'h7FD, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== 64'h5555_6666_7777_8888 || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL last_word_read: rdata=%h rresp=%b expected 5555666677778888/00", d, resp);
      end
   endtask

   task automatic test_backpressure;
      logic [63:0] exp0, exp1; int c; bit hs;
      exp0 = m_rdata(BASE + 32'h10);
      exp1 = m_rdata(BASE + 32'h18);
      araddr = BASE + 32'h10; arvalid = 1; hs = 0; c = 0;
      while (!hs && c < 60) begin hs = arready; @(posedge clk); #1; c++; end
      araddr = BASE + 32'h18;
      c = 0;
      while (!rvalid && c < 60) begin @(posedge clk); #1; c++; end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rvalid !== 1'b1 || rdata !== exp0 || rresp !== 2'b00 || arready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b expected 1/%h/00/0",
                     i, rvalid, rdata, rresp, arready, exp0);
         end
         @(posedge clk); #1;
      end
      rready = 1;
      vectors++;
      if (arready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_ar_during_rhs: arready=%b expected 0", arready);
      end
      @(posedge clk); #1;
      rready = 0;
      vectors++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_after_rhs: rvalid=%b arready=%b expected 0/1", rvalid, arready);
      end
      @(posedge clk); #1;
      arvalid = 0;
      c = 0;
      while (!rvalid && c < 60) begin @(posedge clk); #1; c++; end
      vectors++;
      if (c !== RD_LAT || rdata !== exp1) begin
         miscompares++;
         $display("FAIL bp_second_read: lat=%0d rdata=%h expected %0d/%h", c, rdata, RD_LAT, exp1);
      end
      rready = 1; @(posedge clk); #1; rready = 0;
   endtask

   task automatic test_reset_midflight;
      logic [1:0] resp; logic [63:0] d, old; int lat; bit to;
      old = m_rdata(BASE + 32'h10);
      araddr = BASE + 32'h10; arvalid = 1;
      awaddr = BASE + 32'h10; awvalid = 1; wdata = ~old; wstrb = 8'hFF; wvalid = 1;
      vectors++;
      if ({arready, awready, wready} !== 3'b111) begin
         miscompares++;
         $display("FAIL midrst_pre_ready: ar/aw/w=%b expected 111", {arready, awready, wready});
      end
      @(posedge clk); #1;
      arvalid = 0; awvalid = 0; wvalid = 0;
      rst = 1;
      @(posedge clk); #1;
      vectors++;
      if ({rvalid, bvalid, arready, awready, wready} !== 5'b0) begin
         miscompares++;
         $display("FAIL midrst_flush: rv/bv/ar/aw/w=%b expected 00000", {rvalid, bvalid, arready, awready, wready});
      end
      rst = 0;
      @(posedge clk); #1;
      vectors++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
         miscompares++;
         $display("FAIL midrst_idle: ar/aw/w/rv/bv=%b expected 11100", {arready, awready, wready, rvalid, bvalid});
      end
      do_read(BASE + 32'h10, 0, d, resp, lat, to);
      vectors++;
      if (to || d !== old || resp !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_contents: rdata=%h expected %h", d, old);
      end
   endtask

   task automatic test_random;
      logic [1:0] resp; logic [63:0] d, wd; logic [31:0] a; logic [7:0] s; int lat; bit to;
      for (int w = 0; w < 16; w++) begin
         wd = {$urandom, $urandom};
         do_write(BASE + 32'(w * 8), wd, 8'hFF, 0, 0, 0, resp, lat, to);
         m_write(BASE + 32'(w * 8), wd, 8'hFF);
      end
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) a = $urandom & 32'h7FFF_FFFF;
            else                           a = 32'h8000_0800 + ($urandom_range(0, 1023) << 3);
         end else begin
            a = BASE + 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
         end
         if ($urandom_range(0, 1) == 0) begin
            wd = {$urandom, $urandom};
            s  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, lat, to);
            m_write(a, wd, s);
            vectors++;
            if (to || resp !== m_resp(a) || lat !== WR_LAT) begin
               miscompares++;
               $display("FAIL rand_write[%0d]: addr=%h to=%0d bresp=%b lat=%0d expected 0/%b/%0d",
                        n, a, to, resp, lat, m_resp(a), WR_LAT);
            end
         end else begin
            do_read(a, $urandom_range(0, 3), d, resp, lat, to);
            vectors++;
            if (to || d !== m_rdata(a) || resp !== m_resp(a) || lat !== RD_LAT) begin
               miscompares++;
               $display("FAIL rand_read[%0d]: addr=%h rdata=%h rresp=%b lat=%0d expected %h/%b/%0d",
                        n, a, d, resp, lat, m_rdata(a), m_resp(a), RD_LAT);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_write_read();
      test_partial_write();
      test_w_before_aw();
      test_decode_errors();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
